// File: rtl/audio_axil_regs_pkg.sv
// Shared definitions for the audio peripheral AXI4-Lite register block.
// Provides the response code, register index map, write/read FSM state
// types and the byte-strobe merge used when a register is written.
package audio_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int NUM_REGS   = 4;
    localparam int REG_CTRL   = 0;
    localparam int REG_SAMPLE = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_CFG    = 3;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS-side master and the audio register
// block. The master modport drives addresses, data, strobes and response
// readies; the slave modport drives the channel readies and responses.
interface audio_axil_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/audio_axil_regs.sv
// AXI4-Lite responder holding the audio peripheral's four 32-bit registers.
// Ports:
//   ACLK, ARESET  - clock and asynchronous active-high reset
//   s_axi         - AXI4-Lite slave bundle (AW/W/B/AR/R channels)
//   reg_out       - current contents of registers 0..3
//   reg_wr_pulse  - one-cycle pulse per register, set the cycle after a write
module audio_axil_regs
    import audio_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    audio_axil_if.slave               s_axi,
    output logic [NUM_REGS-1:0][31:0] reg_out,
    output logic [NUM_REGS-1:0]       reg_wr_pulse
);

    if (C_S_AXI_DATA_WIDTH != 32 || C_S_AXI_ADDR_WIDTH != 4) begin : g_param_check
        $error("audio_axil_regs supports only 32-bit data and 4-bit addresses");
    end

    wr_state_e                 wstate_q;
    rd_state_e                 rstate_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic                      aw_held_q, w_held_q;
    logic [1:0]                awidx_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic [NUM_REGS-1:0][31:0] regs_q;
    logic [NUM_REGS-1:0]       pulse_q;
    logic                      arready_q, rvalid_q;
    logic [31:0]               rdata_q;

    logic                      aw_hs_d, w_hs_d, aw_have_d, w_have_d;
    logic [1:0]                wr_idx_d;
    logic [31:0]               wr_data_d;
    logic [3:0]                wr_strb_d;

    // A channel counts as present either from an earlier latch or from a
    // handshake this cycle, so AW and W may complete in any order.
    always_comb begin
        aw_hs_d   = s_axi.awvalid & awready_q;
        w_hs_d    = s_axi.wvalid & wready_q;
        aw_have_d = aw_held_q | aw_hs_d;
        w_have_d  = w_held_q | w_hs_d;
        wr_idx_d  = aw_held_q ? awidx_q : s_axi.awaddr[3:2];
        wr_data_d = w_held_q ? wdata_q : s_axi.wdata;
        wr_strb_d = w_held_q ? wstrb_q : s_axi.wstrb;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            regs_q    <= '0;
            pulse_q   <= '0;
        end else begin
            pulse_q <= '0;
            case (wstate_q)
                W_IDLE: begin
                    if (aw_have_d && w_have_d) begin
                        regs_q[wr_idx_d]  <= apply_wstrb(regs_q[wr_idx_d], wr_data_d, wr_strb_d);
                        pulse_q[wr_idx_d] <= 1'b1;
                        bvalid_q          <= 1'b1;
                        awready_q         <= 1'b0;
                        wready_q          <= 1'b0;
                        aw_held_q         <= 1'b0;
                        w_held_q          <= 1'b0;
                        wstate_q          <= W_RESP;
                    end else begin
                        if (aw_hs_d) begin
                            awidx_q   <= s_axi.awaddr[3:2];
                            aw_held_q <= 1'b1;
                            awready_q <= 1'b0;
                        end
                        if (w_hs_d) begin
                            wdata_q  <= s_axi.wdata;
                            wstrb_q  <= s_axi.wstrb;
                            w_held_q <= 1'b1;
                            wready_q <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs_q before this edge's write lands, so a same-cycle
    // write to the same register returns the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        rdata_q   <= regs_q[s_axi.araddr[3:2]];
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = AXI_RESP_OKAY;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = AXI_RESP_OKAY;
    assign reg_out       = regs_q;
    assign reg_wr_pulse  = pulse_q;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
